// File: rtl/stream_pattern_matcher.sv
// Flags a programmable, per-symbol-masked sequence in a received symbol stream and keeps a
// saturating hit count. Overlapping or non-overlapping detection is selectable.
module stream_pattern_matcher #(
    parameter int DATA_W  = 8,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      cfg_load,
    input  logic [DATA_W*PAT_LEN-1:0] cfg_pattern,
    input  logic [DATA_W*PAT_LEN-1:0] cfg_mask,
    input  logic                      overlap_en,
    input  logic                      count_clr,
    output logic                      match,
    output logic [CNT_W-1:0]          match_count,
    output logic                      armed
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef logic [PAT_LEN-1:0][DATA_W-1:0] sym_vec_t;

    sym_vec_t          win_q, win_d;
    sym_vec_t          pat_q, mask_q;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              match_q, match_d;
    logic              armed_q, armed_d;
    logic              sym_acc;
    logic              hit;

    // A symbol arriving together with cfg_load is discarded.
    assign sym_acc = in_valid & ~cfg_load;

    always_comb begin
        win_d = win_q;
        if (sym_acc) begin
            for (int k = 0; k < PAT_LEN - 1; k++) begin
                win_d[k] = win_q[k+1];
            end
            win_d[PAT_LEN-1] = in_data;
        end

        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

        // Hit is judged on the post-shift window so the last symbol counts this cycle.
        hit = sym_acc && (fill_inc == FILL_FULL);
        for (int k = 0; k < PAT_LEN; k++) begin
            if (((win_d[k] ^ pat_q[k]) & mask_q[k]) != '0) begin
                hit = 1'b0;
            end
        end

        fill_d = fill_q;
        if (cfg_load) begin
            fill_d = '0;
        end else if (in_valid) begin
            fill_d = (hit && !overlap_en) ? '0 : fill_inc;
        end

        armed_d = (fill_d == FILL_FULL);
        match_d = hit;

        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            pat_q   <= '0;
            mask_q  <= '1;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            armed_q <= armed_d;
            if (cfg_load) begin
                pat_q  <= cfg_pattern;
                mask_q <= cfg_mask;
            end
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign armed       = armed_q;

endmodule

// File: tb/tb_stream_pattern_matcher.sv
// Scoreboard bench for stream_pattern_matcher: a symbol-history model predicts match, count
// and armed for every cycle; directed scenarios also check pulse totals.
module tb_stream_pattern_matcher;

    localparam int DW = 8;
    localparam int PL = 4;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             cfg_load;
    logic [DW*PL-1:0] cfg_pattern;
    logic [DW*PL-1:0] cfg_mask;
    logic             overlap_en;
    logic             count_clr;
    logic             match;
    logic [CW-1:0]    match_count;
    logic             armed;

    always #5 clk = ~clk;

    stream_pattern_matcher #(.DATA_W(DW), .PAT_LEN(PL), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .overlap_en  (overlap_en),
        .count_clr   (count_clr),
        .match       (match),
        .match_count (match_count),
        .armed       (armed)
    );

    typedef struct {
        logic m;
        int   cnt;
        logic arm;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_pat[PL];
    logic [7:0]  m_mask[PL];
    logic [7:0]  fresh[$];
    int          m_cnt;
    int          pulses;
    int          checks = 0;
    int          errors = 0;
    string       cur = "init";

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", cur, tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < PL; k++) begin
            m_pat[k]  = 8'h00;
            m_mask[k] = 8'hFF;
        end
        fresh.delete();
        m_cnt = 0;
    endtask

    // Drives one clock cycle, predicts the outputs after the edge and compares them.
    task automatic cycle(input logic v, input logic [7:0] d, input logic ld, input logic clr);
        exp_t e;
        logic hit;
        in_valid  = v;
        in_data   = d;
        cfg_load  = ld;
        count_clr = clr;
        hit = 1'b0;
        if (ld) begin
            for (int k = 0; k < PL; k++) begin
                m_pat[k]  = cfg_pattern[k*8 +: 8];
                m_mask[k] = cfg_mask[k*8 +: 8];
            end
            fresh.delete();
        end else if (v) begin
            fresh.push_back(d);
            if (fresh.size() > PL) void'(fresh.pop_front());
            if (fresh.size() == PL) begin
                hit = 1'b1;
                for (int k = 0; k < PL; k++) begin
                    if (((fresh[k] ^ m_pat[k]) & m_mask[k]) != 8'h00) hit = 1'b0;
                end
            end
            if (hit && !overlap_en) fresh.delete();
        end
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < 15) m_cnt++;
        e.m   = hit;
        e.cnt = m_cnt;
        e.arm = (fresh.size() == PL);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("match", 32'(match), 32'(e.m));
        check_eq("count", 32'(match_count), 32'(e.cnt));
        check_eq("armed", 32'(armed), 32'(e.arm));
        if (match === 1'b1) pulses++;
        in_valid  = 1'b0;
        cfg_load  = 1'b0;
        count_clr = 1'b0;
    endtask

    task automatic load(input logic [31:0] pat, input logic [31:0] msk);
        cfg_pattern = pat;
        cfg_mask    = msk;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [7:0] syms[$], input int maxgap);
        foreach (syms[i]) begin
            cycle(1'b1, syms[i], 1'b0, 1'b0);
            repeat ($urandom_range(0, maxgap)) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic clear_count();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        pulses = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_mask    = '0;
        overlap_en  = 1'b1;
        count_clr   = 1'b0;
        pulses      = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cur = "reset";
        check_eq("match", 32'(match), 0);
        check_eq("count", 32'(match_count), 0);
        check_eq("armed", 32'(armed), 0);
        rst_n = 1'b1;

        // Basic hit with random idle gaps
        cur = "basic";
        load(32'h30313130, 32'hFFFFFFFF);
        clear_count();
        send('{8'h30, 8'h31, 8'h31, 8'h30}, 3);
        check_eq("pulses", 32'(pulses), 1);
        check_eq("count_end", 32'(match_count), 1);
        check_eq("armed_end", 32'(armed), 1);

        // Overlapping detection
        cur = "overlap";
        overlap_en = 1'b1;
        load(32'h30313130, 32'hFFFFFFFF);
        clear_count();
        send('{8'h30, 8'h31, 8'h31, 8'h30, 8'h31, 8'h31, 8'h30}, 0);
        check_eq("pulses", 32'(pulses), 2);
        check_eq("count_end", 32'(match_count), 2);

        // Non-overlapping detection
        cur = "nonoverlap";
        overlap_en = 1'b0;
        load(32'h30313130, 32'hFFFFFFFF);
        clear_count();
        send('{8'h30, 8'h31, 8'h31, 8'h30}, 0);
        check_eq("armed_after_hit", 32'(armed), 0);
        send('{8'h31, 8'h31, 8'h30}, 1);
        check_eq("pulses", 32'(pulses), 1);
        check_eq("count_end", 32'(match_count), 1);

        // Near misses and cfg_load interrupting a partial match
        cur = "nearmiss";
        overlap_en = 1'b1;
        load(32'h30313130, 32'hFFFFFFFF);
        clear_count();
        send('{8'h31, 8'h31, 8'h31, 8'h31, 8'h30, 8'h31, 8'h31, 8'h31, 8'h30, 8'h31, 8'h31}, 1);
        load(32'h30313130, 32'hFFFFFFFF);
        check_eq("armed_after_load", 32'(armed), 0);
        cfg_pattern = '0;
        cycle(1'b1, 8'h30, 1'b1, 1'b0);
        check_eq("pulses", 32'(pulses), 0);
        check_eq("count_end", 32'(match_count), 0);

        // Don't-care mask on the middle symbols
        cur = "mask";
        overlap_en = 1'b0;
        load(32'h30313130, 32'hFF0000FF);
        clear_count();
        send('{8'h30, 8'hAA, 8'h55, 8'h30}, 2);
        check_eq("pulses_hit", 32'(pulses), 1);
        send('{8'h31, 8'hAA, 8'h55, 8'h30}, 2);
        check_eq("pulses_miss", 32'(pulses), 1);

        // Saturation, then clear on a hit cycle
        cur = "saturate";
        overlap_en = 1'b1;
        load(32'h30313130, 32'hFFFFFFFF);
        clear_count();
        send('{8'h30, 8'h31, 8'h31, 8'h30}, 0);
        for (int i = 0; i < 16; i++) send('{8'h31, 8'h31, 8'h30}, 0);
        check_eq("pulses", 32'(pulses), 17);
        check_eq("count_sat", 32'(match_count), 15);
        send('{8'h31, 8'h31}, 0);
        cycle(1'b1, 8'h30, 1'b0, 1'b1);
        check_eq("clr_match", 32'(match), 1);
        check_eq("clr_count", 32'(match_count), 0);

        // Asynchronous reset mid-sequence, then no match without reload
        cur = "async_reset";
        load(32'h30313130, 32'hFFFFFFFF);
        send('{8'h30, 8'h31, 8'h31, 8'h30, 8'h31, 8'h31}, 0);
        check_eq("pre_count", 32'(match_count), 1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_match", 32'(match), 0);
        check_eq("rst_count", 32'(match_count), 0);
        check_eq("rst_armed", 32'(armed), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        send('{8'h30, 8'h31, 8'h31, 8'h30}, 1);
        check_eq("pulses_no_cfg", 32'(pulses), 0);
        check_eq("armed_no_cfg", 32'(armed), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_pattern_matcher.md
Name: stream_pattern_matcher

Overview:
Sequential successor to the fixed 4-bit combinational detector. It watches the byte stream leaving the UART receiver and flags a programmable multi-byte sequence with a per-byte don't-care mask. Overlapping or non-overlapping detection is selectable, and a saturating hit counter is kept. It sits between uart_rx and the status/LED logic.

Parameters:
DATA_W, 8, width of one stream symbol (bits)
PAT_LEN, 4, pattern length in symbols; legal range 1..16
CNT_W, 16, width of match_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is a new received symbol this cycle
in_data  input  DATA_W  received symbol
cfg_load  input  1  latch cfg_pattern/cfg_mask into internal registers
cfg_pattern  input  DATA_W*PAT_LEN  symbol k at bits [k*DATA_W +: DATA_W]; k=0 is the first symbol in arrival order
cfg_mask  input  DATA_W*PAT_LEN  same layout; bit=1 compares, bit=0 is don't-care
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
count_clr  input  1  synchronous clear of match_count
match  output  1  one-cycle pulse per detected occurrence
match_count  output  CNT_W  saturating count of matches
armed  output  1  window holds PAT_LEN valid symbols

Behaviour:
- Reset (async, rst_n=0):
  - window, fill counter, pattern regs, match, match_count, armed all go to 0.
  - mask regs go to all ones.
- Window: a shift register of PAT_LEN symbols. On in_valid the newest symbol enters slot PAT_LEN-1 and the oldest drops out of slot 0, so slot k aligns with pattern symbol k.
- fill: counter of width clog2(PAT_LEN+1). It increments on each accepted symbol and saturates at PAT_LEN. armed = (fill==PAT_LEN), registered.
- Hit condition, evaluated on the next window/fill:
  - in_valid=1 and fill_next==PAT_LEN, and
  - for all k, ((win_next[k] ^ pat[k]) & mask[k]) == 0.
- Latency: match is registered. It is high exactly the cycle after the in_valid cycle carrying the last pattern symbol. It never stays high 2 cycles unless a hit also occurs on the following in_valid.
- overlap_en=1: the window and fill are kept after a hit. overlap_en is sampled on the hit cycle.
- overlap_en=0: on a hit, fill_next is forced to 0 (window contents retained but disarmed). The next hit needs PAT_LEN fresh symbols.
- match_count:
  - +1 on each hit; holds at 2^CNT_W-1 (no wrap).
  - count_clr has priority: a hit in the same cycle is not counted, and the count goes to 0.
- cfg_load:
  - Copies cfg_pattern/cfg_mask into internal regs and sets fill to 0.
  - Window data is not cleared; match_count is kept.
  - If in_valid is also high that cycle, cfg_load wins, the symbol is discarded and no hit is evaluated.
- cfg_pattern/cfg_mask are only sampled on cfg_load; changing them at other times has no effect.
- All-zero mask: every symbol hits once armed (overlap mode), or every PAT_LEN-th symbol hits (non-overlap).
- PAT_LEN=1: a hit is judged on the current symbol alone; armed is high after the first symbol.
- No in_valid: state holds indefinitely; gaps between symbols do not break a sequence.
- Reset mid-sequence: a partial match is lost, the pattern returns to 0, the mask returns to all ones, and software must re-issue cfg_load.

Test Plan:
Use DATA_W=8, PAT_LEN=4, CNT_W=4. Pattern "0110" = 0x30,0x31,0x31,0x30, mask all ones, loaded via cfg_load.
1. Basic hit: send 30 31 31 30 with 0–3 idle cycles between symbols -> match pulses once, 1 cycle after the 4th in_valid; match_count=1; armed=1 after the 4th symbol.
2. Overlap: overlap_en=1, send 30 31 31 30 31 31 30 -> 2 match pulses (after symbols 4 and 7), count=2. Repeat with overlap_en=0 -> 1 pulse, count=1, armed=0 right after the hit.
3. Near misses: send 31 31 31 31, then 30 31 31 31, then 3 symbols 30 31 31 followed by cfg_load -> no match, count=0; fill=0 after cfg_load.
4. Mask: load mask FF,00,00,FF, send 30 AA 55 30 -> match=1. Send 31 AA 55 30 -> no match.
5. Saturation/clear: 17 overlapping hits -> count stops at 15. Assert count_clr on the same cycle as a hit -> count=0 and match still pulses.
6. Async reset: assert rst_n=0 mid-clock after 30 31 31 -> outputs 0 immediately. Release, send 30 31 31 30 without cfg_load -> no match (pattern regs are 0, mask all ones).
